// File: rtl/riscv_tcm_mem.sv
// riscv_tcm_mem: tightly-coupled single-cycle RAM shared by the fetch and
// data ports of riscv_core. Both ports always accept and answer on the next
// clock edge. A backdoor task 'write' preloads program images in simulation.
// Optional feature: define TCM_ADDR_CHECK_EN to flag requests outside the
// BASE_ADDR window with an error response instead of wrapping.

module riscv_tcm_mem #(
    parameter int          MEM_SIZE_W = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [31:0] mem_i_inst_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int DEPTH = 2 ** (MEM_SIZE_W - 2);

    logic [31:0] ram [0:DEPTH-1];

    logic [MEM_SIZE_W-3:0] i_idx;
    logic [MEM_SIZE_W-3:0] d_idx;
    logic                  i_bad;
    logic                  d_bad;
    logic                  d_req;
    logic                  d_store;
    logic                  d_access;
    logic                  unused_ok;

    assign i_idx    = mem_i_pc_i[MEM_SIZE_W-1:2];
    assign d_idx    = mem_d_addr_i[MEM_SIZE_W-1:2];
    assign d_store  = |mem_d_wr_i;
    assign d_access = mem_d_rd_i | d_store;
    assign d_req    = d_access | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;

`ifdef TCM_ADDR_CHECK_EN
    // Anything outside the RAM window is answered with an error, never touching the array
    assign i_bad = (mem_i_pc_i[31:MEM_SIZE_W]   != BASE_ADDR[31:MEM_SIZE_W]);
    assign d_bad = (mem_d_addr_i[31:MEM_SIZE_W] != BASE_ADDR[31:MEM_SIZE_W]);
    assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                         mem_i_pc_i[1:0], mem_d_addr_i[1:0]};
`else
    // Upper address bits are ignored, so the RAM simply aliases across the address space
    assign i_bad = 1'b0;
    assign d_bad = 1'b0;
    assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                         mem_i_pc_i, mem_d_addr_i, BASE_ADDR};
`endif

    assign mem_i_accept_o = 1'b1;
    assign mem_d_accept_o = 1'b1;

    // Byte-lane stores; the array has no reset so it maps onto plain RAM
    always @(posedge clk_i) begin
        if (d_store && !d_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_d_wr_i[b]) begin
                    ram[d_idx][b*8 +: 8] <= mem_d_data_wr_i[b*8 +: 8];
                end
            end
        end
    end

    // Fetch response: one cycle latency, word held while no fetch is requested
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_i_valid_o <= 1'b0;
            mem_i_error_o <= 1'b0;
            mem_i_inst_o  <= 32'h0;
        end else begin
            mem_i_valid_o <= mem_i_rd_i;
            mem_i_error_o <= mem_i_rd_i & i_bad;
            if (mem_i_rd_i) begin
                mem_i_inst_o <= i_bad ? 32'h0 : ram[i_idx];
            end
        end
    end

    // Data response: ack and tag echo per request, load data read before the same-edge store
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_d_ack_o      <= 1'b0;
            mem_d_error_o    <= 1'b0;
            mem_d_data_rd_o  <= 32'h0;
            mem_d_resp_tag_o <= 11'h0;
        end else begin
            mem_d_ack_o   <= d_req;
            mem_d_error_o <= d_req & d_bad;
            if (d_req) begin
                mem_d_resp_tag_o <= mem_d_req_tag_i;
                mem_d_data_rd_o  <= (d_access && !d_bad) ? ram[d_idx] : 32'h0;
            end
        end
    end

    // Simulation backdoor: addr is a byte offset into the RAM, not a bus address
    task automatic write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[MEM_SIZE_W-1:2]][{addr[1:0], 3'b000} +: 8] <= data;
    endtask

endmodule

// File: tb/tb_riscv_tcm_mem.sv
// Directed testbench for riscv_tcm_mem. Inputs change 1ns after a rising
// edge and outputs are sampled 1ns after the following rising edge.
// Define TCM_ADDR_CHECK_EN for both files to exercise the address-check build.

module tb_riscv_tcm_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd, i_flush, i_inv;
    logic [31:0] i_pc;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd;
    logic [3:0]  d_wr;
    logic        d_cacheable;
    logic [10:0] d_tag;
    logic        d_inv, d_wb, d_flush;
    logic        i_accept, i_valid, i_error;
    logic [31:0] i_inst, d_rdata;
    logic        d_accept, d_ack, d_error;
    logic [10:0] d_resp_tag;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    riscv_tcm_mem dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_i_rd_i         (i_rd),
        .mem_i_flush_i      (i_flush),
        .mem_i_invalidate_i (i_inv),
        .mem_i_pc_i         (i_pc),
        .mem_d_addr_i       (d_addr),
        .mem_d_data_wr_i    (d_wdata),
        .mem_d_rd_i         (d_rd),
        .mem_d_wr_i         (d_wr),
        .mem_d_cacheable_i  (d_cacheable),
        .mem_d_req_tag_i    (d_tag),
        .mem_d_invalidate_i (d_inv),
        .mem_d_writeback_i  (d_wb),
        .mem_d_flush_i      (d_flush),
        .mem_i_accept_o     (i_accept),
        .mem_i_valid_o      (i_valid),
        .mem_i_error_o      (i_error),
        .mem_i_inst_o       (i_inst),
        .mem_d_data_rd_o    (d_rdata),
        .mem_d_accept_o     (d_accept),
        .mem_d_ack_o        (d_ack),
        .mem_d_error_o      (d_error),
        .mem_d_resp_tag_o   (d_resp_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rd = 0; i_flush = 0; i_inv = 0; i_pc = 32'h0;
        d_addr = 32'h0; d_wdata = 32'h0; d_rd = 0; d_wr = 4'h0;
        d_cacheable = 0; d_tag = 11'h0; d_inv = 0; d_wb = 0; d_flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        i_rd = 1; i_pc = 32'h80000000; d_rd = 1; d_tag = 11'h55;
        step();
        total++;
        if ({i_valid, i_error, d_ack, d_error} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {i_valid, i_error, d_ack, d_error});
        else passed++;
        total++;
        if ({i_inst, d_rdata, d_resp_tag} !== 75'h0) $display("FAIL reset_data got inst=%h rd=%h tag=%h want 0", i_inst, d_rdata, d_resp_tag);
        else passed++;
        total++;
        if ({i_accept, d_accept} !== 2'b11) $display("FAIL reset_accept got %b want 11", {i_accept, d_accept});
        else passed++;
        idle();
        rst = 0;
        step();
        step();
        total++;
        if ({i_valid, d_ack} !== 2'b00) $display("FAIL post_reset_idle got %b want 00", {i_valid, d_ack});
        else passed++;
    endtask

    task automatic test_fetch();
        dut.write(32'h0, 8'h11);
        dut.write(32'h1, 8'h00);
        dut.write(32'h2, 8'h10);
        dut.write(32'h3, 8'h20);
        #1;
        i_rd = 1; i_pc = 32'h80000000; i_flush = 1; i_inv = 1;
        step();
        total++;
        if (i_valid !== 1'b1 || i_inst !== 32'h20100011) $display("FAIL fetch_word got v=%b inst=%h want v=1 inst=20100011", i_valid, i_inst);
        else passed++;
        idle();
        step();
        total++;
        if (i_valid !== 1'b0 || i_inst !== 32'h20100011) $display("FAIL fetch_hold got v=%b inst=%h want v=0 inst=20100011", i_valid, i_inst);
        else passed++;
    endtask

    task automatic test_store();
        for (int k = 16; k < 20; k++) dut.write(k, 8'h00);
        #1;
        d_addr = 32'h80000010; d_wdata = 32'hAABBCCDD; d_wr = 4'b0101; d_tag = 11'h2A5;
        step();
        total++;
        if (d_ack !== 1'b1 || d_resp_tag !== 11'h2A5 || d_rdata !== 32'h0) $display("FAIL store_ack got ack=%b tag=%h rd=%h want ack=1 tag=2a5 rd=0", d_ack, d_resp_tag, d_rdata);
        else passed++;
        idle();
        d_addr = 32'h80000010; d_rd = 1; d_tag = 11'h155;
        step();
        total++;
        if (d_ack !== 1'b1 || d_resp_tag !== 11'h155 || d_rdata !== 32'h00BB00DD) $display("FAIL store_lanes got ack=%b tag=%h rd=%h want ack=1 tag=155 rd=00bb00dd", d_ack, d_resp_tag, d_rdata);
        else passed++;
        idle();
        step();
        total++;
        if (d_ack !== 1'b0) $display("FAIL store_single_ack got ack=%b want 0", d_ack);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp   [3];
        addrs[0] = 32'h80000000; exp[0] = 32'h20100011;
        addrs[1] = 32'h80000010; exp[1] = 32'h00BB00DD;
        addrs[2] = 32'h80000000; exp[2] = 32'h20100011;
        for (int k = 0; k < 3; k++) begin
            d_rd = 1; d_addr = addrs[k]; d_tag = 11'(k + 1);
            step();
            total++;
            if (d_ack !== 1'b1 || d_resp_tag !== 11'(k + 1) || d_rdata !== exp[k]) $display("FAIL b2b_load%0d got ack=%b tag=%h rd=%h want ack=1 tag=%h rd=%h", k, d_ack, d_resp_tag, d_rdata, 11'(k + 1), exp[k]);
            else passed++;
        end
        idle();
        step();
        total++;
        if (d_ack !== 1'b0) $display("FAIL b2b_end got ack=%b want 0", d_ack);
        else passed++;
    endtask

    task automatic test_fetch_store_collision();
        for (int k = 32; k < 36; k++) dut.write(k, 8'h00);
        #1;
        i_rd = 1; i_pc = 32'h80000020;
        d_addr = 32'h80000020; d_wdata = 32'h12345678; d_wr = 4'hF; d_tag = 11'h7;
        step();
        total++;
        if (i_valid !== 1'b1 || i_inst !== 32'h0 || d_ack !== 1'b1 || d_rdata !== 32'h0) $display("FAIL collide_old got v=%b inst=%h ack=%b rd=%h want 1 0 1 0", i_valid, i_inst, d_ack, d_rdata);
        else passed++;
        idle();
        i_rd = 1; i_pc = 32'h80000020;
        step();
        total++;
        if (i_inst !== 32'h12345678) $display("FAIL collide_new got inst=%h want 12345678", i_inst);
        else passed++;
        idle();
    endtask

    task automatic test_rd_with_wr_and_maint();
        d_rd = 1; d_wr = 4'b1000; d_addr = 32'h80000010; d_wdata = 32'h99000000; d_tag = 11'h0A;
        step();
        total++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h00BB00DD) $display("FAIL rdwr_old got ack=%b rd=%h want ack=1 rd=00bb00dd", d_ack, d_rdata);
        else passed++;
        idle();
        d_flush = 1; d_addr = 32'h80000010; d_wdata = 32'hFFFFFFFF; d_tag = 11'h3FF;
        step();
        total++;
        if (d_ack !== 1'b1 || d_resp_tag !== 11'h3FF || d_rdata !== 32'h0) $display("FAIL maint_ack got ack=%b tag=%h rd=%h want ack=1 tag=3ff rd=0", d_ack, d_resp_tag, d_rdata);
        else passed++;
        idle();
        d_inv = 1; d_wb = 1; d_addr = 32'h80000010; d_tag = 11'h0B;
        step();
        idle();
        d_rd = 1; d_addr = 32'h80000010; d_tag = 11'h0C;
        step();
        total++;
        if (d_rdata !== 32'h99BB00DD || d_resp_tag !== 11'h0C) $display("FAIL rdwr_new got rd=%h tag=%h want rd=99bb00dd tag=00c", d_rdata, d_resp_tag);
        else passed++;
        idle();
    endtask

    task automatic test_addr_check();
        d_rd = 1; d_addr = 32'h00000000; d_tag = 11'h11;
        i_rd = 1; i_pc = 32'h00000010;
        step();
`ifdef TCM_ADDR_CHECK_EN
        total++;
        if (d_ack !== 1'b1 || d_error !== 1'b1 || d_rdata !== 32'h0) $display("FAIL addr_check_load got ack=%b err=%b rd=%h want 1 1 0", d_ack, d_error, d_rdata);
        else passed++;
        total++;
        if (i_valid !== 1'b1 || i_error !== 1'b1 || i_inst !== 32'h0) $display("FAIL addr_check_fetch got v=%b err=%b inst=%h want 1 1 0", i_valid, i_error, i_inst);
        else passed++;
`else
        total++;
        if (d_ack !== 1'b1 || d_error !== 1'b0 || d_rdata !== 32'h20100011) $display("FAIL addr_wrap_load got ack=%b err=%b rd=%h want 1 0 20100011", d_ack, d_error, d_rdata);
        else passed++;
        total++;
        if (i_valid !== 1'b1 || i_error !== 1'b0 || i_inst !== 32'h99BB00DD) $display("FAIL addr_wrap_fetch got v=%b err=%b inst=%h want 1 0 99bb00dd", i_valid, i_error, i_inst);
        else passed++;
`endif
        idle();
    endtask

    task automatic test_reset_mid_request();
        i_rd = 1; i_pc = 32'h80000000; d_rd = 1; d_addr = 32'h80000000; d_tag = 11'h44;
        step();
        total++;
        if (i_valid !== 1'b1 || d_ack !== 1'b1) $display("FAIL midrst_pre got v=%b ack=%b want 1 1", i_valid, d_ack);
        else passed++;
        rst = 1;
        #1;
        total++;
        if (i_valid !== 1'b0 || d_ack !== 1'b0 || d_resp_tag !== 11'h0) $display("FAIL midrst_clear got v=%b ack=%b tag=%h want 0 0 0", i_valid, d_ack, d_resp_tag);
        else passed++;
        step();
        idle();
        rst = 0;
        step();
        total++;
        if (i_valid !== 1'b0 || d_ack !== 1'b0) $display("FAIL midrst_after got v=%b ack=%b want 0 0", i_valid, d_ack);
        else passed++;
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_fetch_store_collision();
        test_rd_with_wr_and_maint();
        test_addr_check();
        test_reset_mid_request();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
